instr_seq_ctrl: RTL and testbench

Instruction sequencer that sits in front of `instruction_decode`. It walks the on-chip instruction memory from a start address and presents one 64-bit instruction at a time on `instruction`/`instr_enable`. It then stalls until the unit targeted by that instruction reports completion. It also implements the end-of-program (0x82) and verification-hold (0x44) opcodes at the sequencing level, with a completion timeout and error reporting.

---
 rtl/instr_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_instr_seq_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: walks instruction memory, issues one instruction at a time and
// stalls until the targeted unit completes; handles END/HOLD opcodes, timeout and errors.
module instr_seq_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              resume,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [63:0]       imem_rdata,
  output logic [63:0]       instruction,
  output logic              instr_enable,
  input  logic              fetch_done,
  input  logic              comp_done,
  output logic              busy,
  output logic              exe_done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       instr_count
);
  typedef enum logic [2:0] {IDLE, READ, LATCH, ISSUE, WAIT, HOLD, DONE, ERR} state_e;
  typedef enum logic [2:0] {C_FETCH, C_COMP, C_CFG, C_END, C_HOLD, C_ILL} cls_e;
  localparam logic [19:0] TMO = TIMEOUT_CYC[19:0];
  state_e            state_q, state_d;
  cls_e              cls_q, cls_d, rd_cls;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;
  logic [63:0]       instr_q, instr_d;
  logic [19:0]       tmo_q, tmo_d;
  logic              hit, adv;
  always_comb begin
    case (imem_rdata[63:56])
      8'h01, 8'h02, 8'h04: rd_cls = C_FETCH;
      8'h81:               rd_cls = C_COMP;
      8'h40:               rd_cls = C_CFG;
      8'h82:               rd_cls = C_END;
      8'h44:               rd_cls = C_HOLD;
      default:             rd_cls = C_ILL;
    endcase
  end
  // Only the pulse matching the outstanding class can release WAIT; pulses outside WAIT are dropped.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    instr_d = instr_q;
    tmo_d   = tmo_q;
    hit     = (cls_q == C_FETCH) ? fetch_done : comp_done;
    adv     = (state_q == ISSUE && cls_q == C_CFG) || (state_q == WAIT && hit) ||
              (state_q == HOLD && resume);
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = READ;
        pc_d    = start_addr;
        cnt_d   = '0;
        err_d   = '0;
      end
      READ: state_d = LATCH;
      LATCH: begin
        instr_d = imem_rdata;
        cls_d   = rd_cls;
        state_d = (rd_cls == C_ILL) ? ERR : ISSUE;
        err_d   = (rd_cls == C_ILL) ? 2'd2 : err_q;
      end
      ISSUE: begin
        cnt_d   = cnt_q + {15'd0, ~&cnt_q};
        tmo_d   = '0;
        state_d = (cls_q == C_END) ? DONE : (cls_q == C_HOLD) ? HOLD : WAIT;
      end
      WAIT: begin
        tmo_d = tmo_q + 20'd1;
        if (!hit && tmo_q == TMO) begin
          state_d = ERR;
          err_d   = 2'd1;
        end
      end
      default: ;
    endcase
    if (adv) begin
      state_d = (&pc_q) ? ERR : READ;
      err_d   = (&pc_q) ? 2'd3 : err_d;
      pc_d    = (&pc_q) ? pc_q : pc_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cls_q   <= C_FETCH;
      pc_q    <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      instr_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      instr_q <= instr_d;
      tmo_q   <= tmo_d;
    end
  end
  assign imem_en      = state_q == READ;
  assign imem_addr    = pc_q;
  assign instruction  = instr_q;
  assign instr_enable = state_q == ISSUE;
  assign busy         = !(state_q == IDLE || state_q == DONE || state_q == ERR);
  assign exe_done     = state_q == DONE;
  assign error        = state_q == ERR;
  assign err_code     = err_q;
  assign pc           = pc_q;
  assign instr_count  = cnt_q;
endmodule

// File: tb/tb_instr_seq_ctrl.sv
// tb_instr_seq_ctrl: random programs plus directed cases, checked against an
// issue-timing model derived from the opcode classes and pulse timing.
module tb_instr_seq_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;

  logic        rst, start, resume, fetch_done, comp_done;
  logic [9:0]  start_addr, imem_addr, pc;
  logic        imem_en, instr_enable, busy, exe_done, error;
  logic [63:0] imem_rdata = '0, instruction;
  logic [1:0]  err_code;
  logic [15:0] instr_count;
  logic [63:0] mem [1024];
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  instr_seq_ctrl #(.ADDR_W(10), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .resume(resume),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_enable(instr_enable),
    .fetch_done(fetch_done), .comp_done(comp_done), .busy(busy), .exe_done(exe_done),
    .error(error), .err_code(err_code), .pc(pc), .instr_count(instr_count));

  logic        b_start, b_resume, b_fd, b_cd, b_en, b_ie, b_busy, b_done, b_err;
  logic [3:0]  b_sa, b_addr, b_pc;
  logic [63:0] b_rdata = '0, b_instr;
  logic [1:0]  b_code;
  logic [15:0] b_cnt;
  logic [63:0] mem_b [16];
  always @(posedge clk) if (b_en) b_rdata <= mem_b[b_addr];

  instr_seq_ctrl #(.ADDR_W(4), .TIMEOUT_CYC(8)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .start_addr(b_sa), .resume(b_resume),
    .imem_en(b_en), .imem_addr(b_addr), .imem_rdata(b_rdata),
    .instruction(b_instr), .instr_enable(b_ie),
    .fetch_done(b_fd), .comp_done(b_cd), .busy(b_busy), .exe_done(b_done),
    .error(b_err), .err_code(b_code), .pc(b_pc), .instr_count(b_cnt));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 0 fetch, 1 comp, 2 cfg, 3 end, 4 hold, 5 illegal
  function automatic int cls_of(input logic [7:0] op);
    return (op == 8'h01 || op == 8'h02 || op == 8'h04) ? 0 : op == 8'h81 ? 1 :
           op == 8'h40 ? 2 : op == 8'h82 ? 3 : op == 8'h44 ? 4 : 5;
  endfunction

  task automatic wait_issue(output int t);
    t = -1;
    for (int i = 0; i < 64; i++) begin
      if (instr_enable) begin
        t = cyc;
        break;
      end
      tick(1);
    end
  endtask

  task automatic start_a(input logic [9:0] a);
    start_addr = a;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("read_after_start", 64'({imem_en, busy, error, exe_done, err_code}), 64'b110000);
    chk("read_addr", 64'(imem_addr), 64'(a));
    chk("count_cleared", 64'(instr_count), 64'd0);
  endtask

  task automatic run_a(input int base, input int hold_d);
    int t_exp, t, k, d, c;
    logic any_rd;
    logic [63:0] w;
    bit early;
    start_a(base[9:0]);
    t_exp = cyc + 2;
    k = 0;
    for (int a = base; a < 1024; a++) begin
      w = mem[10'(a)];
      c = cls_of(w[63:56]);
      if (c == 5) begin
        tick(t_exp - cyc);
        chk("illegal_err", 64'({error, err_code}), 64'b110);
        chk("illegal_cnt", 64'(instr_count), 64'(k));
        return;
      end
      wait_issue(t);
      chk("issue_cycle", 64'(t), 64'(t_exp));
      chk("issue_word", instruction, w);
      if (t < 0) return;
      k++;
      if (c == 3) begin
        tick(1);
        chk("done_flags", 64'({exe_done, busy, error}), 64'b100);
        chk("done_pc", 64'(pc), 64'(a));
        chk("done_cnt", 64'(instr_count), 64'(k));
        return;
      end
      d = (c == 2) ? 0 : (hold_d > 0) ? hold_d : int'($urandom_range(1, 20));
      early = $urandom_range(0, 1) == 1;
      any_rd = 1'b0;
      for (int j = 0; j <= d; j++) begin
        fetch_done = (c == 0 && (j == d || (j == 0 && early))) || (c == 1 && j == 1 && d >= 3);
        comp_done  = (c == 1 && (j == d || (j == 0 && early))) || (c == 0 && j == 1 && d >= 3);
        resume     = (c == 4 && j == d) || (c < 2 && j == 2);
        start      = c == 4 && j == 2 && d >= 4;
        start_addr = '0;
        any_rd |= imem_en;
        tick(1);
      end
      {fetch_done, comp_done, resume, start} = '0;
      chk("stall_no_read", 64'(any_rd), 64'd0);
      t_exp = t + d + 3;
    end
  endtask

  task automatic gen(input int base, input int n);
    logic [7:0] ops [6] = '{8'h01, 8'h02, 8'h04, 8'h81, 8'h40, 8'h44};
    logic [7:0] bad [4] = '{8'h33, 8'h00, 8'hFF, 8'h83};
    logic [63:0] w;
    for (int i = 0; i <= n; i++) begin
      w = {$urandom, $urandom};
      w[63:56] = (i == n) ? 8'h82 : ops[3'($urandom_range(0, 5))];
      mem[10'(base + i)] = w;
    end
    if ($urandom_range(0, 3) == 0) mem[10'(base + int'($urandom_range(0, n - 1)))][63:56] = bad[2'($urandom_range(0, 3))];
  endtask

  task automatic start_b(input logic [3:0] a);
    b_sa = a;
    b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    chk("b_read_after_start", 64'({b_en, b_err, b_code}), 64'b1000);
    chk("b_read_addr", 64'(b_addr), 64'(a));
  endtask

  initial begin
    int base, n, t;
    {rst, start, resume, fetch_done, comp_done} = 5'b10000;
    {b_start, b_resume, b_fd, b_cd} = '0;
    start_addr = '0;
    b_sa = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) mem_b[i] = '0;
    tick(3);
    chk("rst_flags", 64'({imem_en, instr_enable, busy, exe_done, error, err_code}), 64'd0);
    chk("rst_vals", 64'({imem_addr, pc, instr_count}), 64'd0);
    chk("rst_instr", instruction, 64'd0);
    chk("b_rst_flags", 64'({b_en, b_ie, b_busy, b_done, b_err, b_code, b_pc, b_cnt}), 64'd0);
    rst = 1'b0;
    tick(1);
    mem[16] = 64'h4000_0000_0000_1234;
    mem[17] = 64'h8200_0000_0000_0000;
    run_a(16, 0);
    mem[32] = 64'h0200_0000_00AB_CDEF;
    mem[33] = 64'h8200_0000_0000_0001;
    run_a(32, 20);
    mem[48] = 64'h4400_0000_0000_0055;
    mem[49] = 64'h8200_0000_0000_0002;
    run_a(48, 50);
    mem[64] = 64'h3300_0000_0000_0000;
    run_a(64, 0);
    for (int r = 0; r < 12; r++) begin
      base = int'($urandom_range(100, 900));
      n = int'($urandom_range(2, 10));
      gen(base, n);
      run_a(base, 0);
    end
    mem[80] = 64'h0100_0000_0000_0077;
    start_a(10'd80);
    wait_issue(t);
    chk("rst_test_issue", 64'(t >= 0), 64'd1);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("midrst_flags", 64'({imem_en, instr_enable, busy, exe_done, error, err_code}), 64'd0);
    chk("midrst_vals", 64'({imem_addr, pc, instr_count}), 64'd0);
    chk("midrst_instr", instruction, 64'd0);
    rst = 1'b0;
    tick(1);
    mem_b[0]  = 64'h8100_0000_0000_0000;
    mem_b[1]  = 64'h8100_0000_0000_0011;
    mem_b[2]  = 64'h8200_0000_0000_0022;
    mem_b[15] = 64'h4000_0000_0000_00FF;
    start_b(4'd0);
    tick(4);
    b_fd = 1'b1;
    tick(1);
    b_fd = 1'b0;
    tick(6);
    chk("b_pre_timeout", 64'({b_err, b_busy}), 64'b01);
    tick(1);
    chk("b_timeout", 64'({b_err, b_code, b_busy}), 64'b1010);
    chk("b_timeout_pc", 64'(b_pc), 64'd0);
    chk("b_timeout_cnt", 64'(b_cnt), 64'd1);
    start_b(4'd15);
    tick(3);
    chk("b_end_of_mem", 64'({b_err, b_code}), 64'b111);
    chk("b_end_pc", 64'(b_pc), 64'hF);
    start_b(4'd1);
    tick(11);
    b_cd = 1'b1;
    tick(1);
    b_cd = 1'b0;
    chk("b_done_beats_timeout", 64'({b_err, b_en}), 64'b01);
    tick(2);
    chk("b_next_issue", 64'(b_ie), 64'd1);
    chk("b_next_word", b_instr, mem_b[2]);
    tick(1);
    chk("b_exe_done", 64'({b_done, b_cnt}), {47'd0, 1'b1, 16'd2});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
